// File: rtl/uart_pkg.sv
// Shared constants for the IO-bus UART transmitter: FSM state encoding,
// 8N1 frame constants and the bit-period clamp helper.
package uart_pkg;

    // FSM state encoding (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Frame constants
    localparam int DATA_BITS  = 8;
    localparam int MIN_PERIOD = 2;

    // Effective bit period: the programmed term, but never shorter than MIN_PERIOD
    function automatic logic [15:0] bit_period(input logic [15:0] term);
        return (term < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : term;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter. DEPTH must be a power of two
// so the read/write pointers wrap naturally modulo DEPTH. A push into a full
// buffer is ignored unless a pop happens on the same edge.
module uart_tx_fifo #(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wr_data,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // A full buffer still accepts a write when the oldest entry leaves this edge
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    // Occupancy update: simultaneous push and pop leave the count unchanged
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count, cleared by reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; the pointers and count make stale entries unreachable.
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

endmodule : uart_tx_fifo

// File: rtl/io_uart_tx.sv
// IO-bus UART transmitter, 8N1 framing, LSB first, idle-high line.
// Bytes are pushed into a small buffer and drained back-to-back by the
// IDLE/START/DATA/STOP frame FSM. The bit period is max(uart_term, 2) clocks,
// latched when a byte is popped so mid-frame changes apply to the next frame.
// Build option: define UART_TX_FIFO_EN to use a TX_DEPTH-entry FIFO; without
// it the buffer is fixed at 2 entries and TX_DEPTH has no effect.
module io_uart_tx
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_io_char,
    input  logic        uart_io_we,
    output logic        uart_io_full,
    input  logic [15:0] uart_term,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_overflow
);

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = TX_DEPTH;
`else
    // TX_DEPTH is ignored in this build; it is referenced only to stay part of the interface
    localparam int DEPTH = 2 + 0 * TX_DEPTH;
`endif
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [15:0]   period_q, period_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, line_d;
    logic          ovf_q;

    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          pop, bit_done;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (uart_io_we),
        .pop     (pop),
        .wr_data (uart_io_char),
        .rd_data (fifo_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Timer counts down from period-1; zero marks the last cycle of a bit
    assign bit_done = (timer_q == '0);

    // Pop when idle, or at the end of a stop bit so the next frame follows with no gap
    assign pop = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_done));

    // One slot is kept free for the write already in flight behind the producer's sample
    assign uart_io_full = (fifo_count >= CW'(DEPTH - 1));
    assign tx_busy      = (state_q != ST_IDLE) | (fifo_count != '0);
    assign tx_overflow  = ovf_q;
    assign uart_tx      = tx_q;

    // Frame FSM, bit timer and shifter next-state
    always_comb begin
        state_d   = state_q;
        timer_d   = bit_done ? timer_q : timer_q - 16'd1;
        period_d  = period_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    timer_d = period_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d   = period_q - 16'd1;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) state_d = ST_IDLE;
            end
            default: ;
        endcase
        // A pop (from IDLE or end of STOP) loads the next frame
        if (pop) begin
            state_d   = ST_START;
            period_d  = bit_period(uart_term);
            timer_d   = bit_period(uart_term) - 16'd1;
            shift_d   = fifo_data;
            bit_idx_d = '0;
        end
    end

    // Line level implied by the current state, registered one cycle later
    always_comb begin
        line_d = 1'b1;
        case (state_q)
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = shift_q[0];
            default:  line_d = 1'b1;
        endcase
    end

    // Transmitter registers; reset returns the line to idle and drops the partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            period_q  <= 16'(MIN_PERIOD);
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= line_d;
            ovf_q     <= uart_io_we & fifo_full & ~pop;
        end
    end

endmodule : io_uart_tx

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx (both buffer build options).
module tb_io_uart_tx;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  uart_io_char = '0;
    logic        uart_io_we = 1'b0;
    logic        uart_io_full;
    logic [15:0] uart_term = 16'd4;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    io_uart_tx #(
        .TX_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_io_char (uart_io_char),
        .uart_io_we   (uart_io_we),
        .uart_io_full (uart_io_full),
        .uart_term    (uart_term),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one rising edge
    task automatic push(input logic [7:0] b);
        uart_io_char = b;
        uart_io_we   = 1'b1;
        tick();
        uart_io_we   = 1'b0;
    endtask

    // Called just after the edge where the start bit appears on the line;
    // every bit must hold its level for exactly p cycles
    task automatic expect_frame(input logic [7:0] b, input int p, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            int good;
            good = 0;
            for (int c = 0; c < p; c++) begin
                if (uart_tx === bits[k]) good++;
                tick();
            end
            check($sformatf("%s bit%0d", tag, k), good, p);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst uart_tx", uart_tx, 1);
        check("rst tx_busy", tx_busy, 0);
        check("rst overflow", tx_overflow, 0);
        check("rst full", uart_io_full, 0);
        rst = 1'b0;
        tick();

        // Single byte 0x55 at 4-cycle bits, 40-cycle frame
        uart_term = 16'd4;
        push(8'h55);
        check("55 busy", tx_busy, 1);
        check("55 full", uart_io_full, (DEPTH == 2) ? 1 : 0);
        tick();
        check("55 line before start", uart_tx, 1);
        tick();
        check("55 busy in frame", tx_busy, 1);
        expect_frame(8'h55, 4, "f55");
        check("55 idle line", uart_tx, 1);
        check("55 busy after", tx_busy, 0);

        // Minimum period clamp
        uart_term = 16'd0;
        push(8'h0F);
        tick(); tick();
        expect_frame(8'h0F, 2, "t0");
        uart_term = 16'd1;
        push(8'hC3);
        tick(); tick();
        expect_frame(8'hC3, 2, "t1");

        // Two consecutive pushes -> back-to-back frames
        uart_term = 16'd3;
        push(8'hA5);
        push(8'h3C);
        tick();
        expect_frame(8'hA5, 3, "fA5");
        expect_frame(8'h3C, 3, "f3C");
        check("b2b idle line", uart_tx, 1);
        check("b2b busy after", tx_busy, 0);

`ifdef UART_TX_FIFO_EN
        // Depth-8 buffer: full at count 7, in-flight ninth accepted, tenth dropped
        uart_term = 16'd100;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    push(8'h10 + 8'(k));
                    check($sformatf("d8 full k%0d", k), uart_io_full, (k >= 7) ? 1 : 0);
                    check($sformatf("d8 ovf k%0d", k), tx_overflow, (k == 9) ? 1 : 0);
                end
                tick();
                check("d8 ovf clears", tx_overflow, 0);
            end
            begin
                repeat (3) tick();
                for (int k = 0; k < 9; k++)
                    expect_frame(8'h10 + 8'(k), 100, $sformatf("d8 byte%0d", k));
            end
        join
        check("d8 busy after", tx_busy, 0);
`else
        // Fixed 2-entry buffer: fourth consecutive push is dropped
        uart_term = 16'd3;
        fork
            begin
                push(8'h81);
                check("d2 full A", uart_io_full, 1);
                push(8'h42);
                check("d2 ovf B", tx_overflow, 0);
                push(8'h24);
                check("d2 ovf C", tx_overflow, 0);
                push(8'hE7);
                check("d2 ovf D", tx_overflow, 1);
                tick();
                check("d2 ovf clears", tx_overflow, 0);
            end
            begin
                repeat (3) tick();
                expect_frame(8'h81, 3, "d2 A");
                expect_frame(8'h42, 3, "d2 B");
                expect_frame(8'h24, 3, "d2 C");
            end
        join
        check("d2 idle line", uart_tx, 1);
        check("d2 busy after", tx_busy, 0);
`endif

        // Period changed mid-frame applies to the next frame only
        uart_term = 16'd5;
        push(8'h96);
        push(8'h69);
        tick();
        uart_term = 16'd8;
        expect_frame(8'h96, 5, "p5");
        expect_frame(8'h69, 8, "p8");
        check("term idle line", uart_tx, 1);

        // Reset during DATA bit 3 with a second byte buffered
        uart_term = 16'd4;
        push(8'hB2);
        push(8'h11);
        tick();
        repeat (17) tick();
        check("mid bit3 low", uart_tx, 0);
        rst = 1'b1;
        tick();
        check("mid rst uart_tx", uart_tx, 1);
        check("mid rst busy", tx_busy, 0);
        check("mid rst full", uart_io_full, 0);
        check("mid rst ovf", tx_overflow, 0);
        rst = 1'b0;
        begin
            int quiet;
            quiet = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (uart_tx === 1'b1 && tx_busy === 1'b0) quiet++;
            end
            check("post rst quiet", quiet, 12);
        end
        push(8'hFF);
        tick(); tick();
        expect_frame(8'hFF, 4, "fFF");
        check("FF busy after", tx_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_io_uart_tx
